uart_rx: RTL and testbench

//  Receive half of the UART: 8N1 serial deserializer with 16x oversampling and a bus-slave register port.

---
 rtl/uart_rx_pkg.sv | 33 +++
 rtl/uart_baud_gen.sv | 29 ++
 rtl/uart_rx.sv | 152 +++++++++++++++
 tb/tb_uart_rx.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// uart_rx_pkg : shared UART receiver constants, status layout, divider
// Rev 1.0
// ------------------------------------------------------------------
package uart_rx_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_STOP  = 3'd3;
  localparam logic [2:0] ST_BREAK = 3'd4;

  localparam logic ADR_RXDATA = 1'b0;
  localparam logic ADR_STATUS = 1'b1;

  localparam logic [3:0] SMP_MID  = 4'd7;
  localparam logic [3:0] SMP_LAST = 4'd15;

  typedef struct packed {
    logic [3:0] rsvd;
    logic       active;
    logic       ferr;
    logic       ovr;
    logic       valid;
  } status_t;

  function automatic int calc_div(input int sys_clk, input int baud, input int os);
    return sys_clk / (baud * os);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_gen.sv
`default_nettype none
// ------------------------------------------------------------------
// uart_baud_gen : 1-cycle tick every DIV clocks, synchronous restart
// Rev 1.0
// ------------------------------------------------------------------
module uart_baud_gen #(
  parameter int DIV = 27
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);
  localparam int CW = $clog2(DIV + 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(DIV - 1));

  always_ff @(posedge clk) begin
    if (rst || restart || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ------------------------------------------------------------------
// uart_rx : 8N1 receiver, 16x oversampling, RXDATA/STATUS bus slave
// Rev 1.0
// ------------------------------------------------------------------
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int SYS_CLK    = 50_000_000,
  parameter int BAUDRATE   = 115200,
  parameter int OVERSAMPLE = 16
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_cyc,
  input  logic       i_we,
  input  logic       i_adr,
  output logic [7:0] o_dat,
  input  logic       rx,
  output logic       o_int
);
  localparam int DIV = calc_div(SYS_CLK, BAUDRATE, OVERSAMPLE);

  logic       sync1;
  logic       rx_s;
  logic [2:0] state;
  logic [3:0] smp;
  logic [2:0] bit_cnt;
  logic [7:0] shreg;
  logic [7:0] rxdata;
  logic       valid;
  logic       ovr;
  logic       ferr;
  logic       rd_d;
  logic       tick;
  logic       rd;
  logic       rd_strobe;
  logic       done;
  status_t    status;

  uart_baud_gen #(.DIV(DIV)) u_baud (
    .clk     (i_clk),
    .rst     (i_reset),
    .restart (state == ST_IDLE),
    .tick    (tick)
  );

  // Only the first cycle of a held RXDATA access clears the flags
  assign rd        = i_cyc & ~i_we & (i_adr == ADR_RXDATA);
  assign rd_strobe = rd & ~rd_d;
  assign done      = (state == ST_STOP) && tick && (smp == SMP_LAST);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= rx;
      rx_s  <= sync1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state   <= ST_IDLE;
      smp     <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          smp     <= '0;
          bit_cnt <= '0;
          if (!rx_s) state <= ST_START;
        end
        ST_START: begin
          if (tick) begin
            if (smp == SMP_MID) begin
              smp     <= '0;
              bit_cnt <= '0;
              state   <= rx_s ? ST_IDLE : ST_DATA;
            end else begin
              smp <= smp + 4'd1;
            end
          end
        end
        ST_DATA: begin
          if (tick) begin
            smp <= smp + 4'd1;
            if (smp == SMP_LAST) begin
              shreg   <= {rx_s, shreg[7:1]};
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) state <= ST_STOP;
            end
          end
        end
        ST_STOP: begin
          if (tick) begin
            smp <= smp + 4'd1;
            if (smp == SMP_LAST) state <= rx_s ? ST_IDLE : ST_BREAK;
          end
        end
        ST_BREAK: begin
          if (rx_s) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // A frame completing alongside a read strobe is delivered, not dropped
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rxdata <= '0;
      valid  <= 1'b0;
      ovr    <= 1'b0;
      ferr   <= 1'b0;
      o_int  <= 1'b0;
      rd_d   <= 1'b0;
    end else begin
      o_int <= done;
      rd_d  <= rd;
      if (done) begin
        if (!valid || rd_strobe) begin
          rxdata <= shreg;
          valid  <= 1'b1;
          ovr    <= 1'b0;
          ferr   <= ~rx_s;
        end else begin
          ovr  <= 1'b1;
          ferr <= ferr | ~rx_s;
        end
      end else if (rd_strobe) begin
        valid <= 1'b0;
        ovr   <= 1'b0;
        ferr  <= 1'b0;
      end
    end
  end

  always_comb begin
    status        = '0;
    status.active = (state != ST_IDLE);
    status.ferr   = ferr;
    status.ovr    = ovr;
    status.valid  = valid;
  end

  assign o_dat = (i_adr == ADR_STATUS) ? status : rxdata;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_uart_rx : directed + random frames against a register-level model
// Rev 1.0
// ------------------------------------------------------------------
module tb_uart_rx;
  logic       clk = 1'b0;
  logic       i_reset, i_cyc, i_we, i_adr, rx;
  logic [7:0] o_dat;
  logic       o_int;

  int n_cmp = 0;
  int n_err = 0;

  // interrupt monitor
  int cyc = 0;
  int n_int = 0;
  int n_wide = 0;
  int last_int_cyc = 0;
  logic int_prev = 1'b0;

  // register-level reference model
  logic [7:0] m_data;
  logic       m_valid, m_ovr, m_ferr;

  uart_rx #(.SYS_CLK(1_600_000), .BAUDRATE(100_000), .OVERSAMPLE(16)) dut (
    .i_clk   (clk),
    .i_reset (i_reset),
    .i_cyc   (i_cyc),
    .i_we    (i_we),
    .i_adr   (i_adr),
    .o_dat   (o_dat),
    .rx      (rx),
    .o_int   (o_int)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (o_int) begin
      n_int++;
      last_int_cyc = cyc;
      if (int_prev) n_wide++;
    end
    int_prev = o_int;
  end

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] m_status(input logic active);
    return {4'b0, active, m_ferr, m_ovr, m_valid};
  endfunction

  function automatic void m_clear();
    m_valid = 1'b0;
    m_ovr   = 1'b0;
    m_ferr  = 1'b0;
  endfunction

  function automatic void m_frame(input logic [7:0] b, input logic stop_ok, input logic strobe);
    if (!m_valid || strobe) begin
      m_data  = b;
      m_valid = 1'b1;
      m_ovr   = 1'b0;
      m_ferr  = !stop_ok;
    end else begin
      m_ovr  = 1'b1;
      m_ferr = m_ferr | !stop_ok;
    end
  endfunction

  task automatic read_status(input string tag, input logic active);
    i_we = 1'b0; i_adr = 1'b1; i_cyc = 1'b1;
    #1 chk_eq(tag, o_dat, m_status(active));
    @(negedge clk);
    i_cyc = 1'b0;
  endtask

  task automatic read_data(input string tag, input int hold);
    i_we = 1'b0; i_adr = 1'b0; i_cyc = 1'b1;
    #1 chk_eq(tag, o_dat, m_data);
    for (int k = 1; k < hold; k++) begin
      @(negedge clk);
      #1 chk_eq({tag, "_held"}, o_dat, m_data);
    end
    @(negedge clk);
    i_cyc = 1'b0;
    m_clear();
  endtask

  task automatic write_cycle();
    i_we = 1'b1; i_adr = 1'b0; i_cyc = 1'b1;
    @(negedge clk);
    i_cyc = 1'b0; i_we = 1'b0;
  endtask

  // One bit = 16 clocks. Mid-stop-bit after 2 sync clocks is 154 clocks
  // from the start edge; the strobe is driven for the completion clock.
  task automatic send_frame(input logic [7:0] b, input logic stop_ok, input logic strobe);
    int t0, n0, lat;
    n0 = n_int;
    t0 = cyc;
    rx = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (16) @(negedge clk);
    end
    rx = stop_ok;
    for (int k = 0; k < 16; k++) begin
      if (strobe && k == 10) begin i_we = 1'b0; i_adr = 1'b0; i_cyc = 1'b1; end
      if (strobe && k == 11) i_cyc = 1'b0;
      @(negedge clk);
    end
    if (stop_ok) rx = 1'b1;
    m_frame(b, stop_ok, strobe);
    chk_eq("int_per_frame", n_int - n0, 1);
    lat = last_int_cyc - t0;
    chk_eq("int_latency_ok", (lat >= 152 && lat <= 157), 1);
  endtask

  initial begin
    logic [7:0] b, pb;
    logic ok;
    int n0;
    i_reset = 1'b1; i_cyc = 1'b0; i_we = 1'b0; i_adr = 1'b0; rx = 1'b1;
    m_data = 8'h00; m_clear();
    repeat (3) @(negedge clk);
    chk_eq("reset_int", o_int, 0);
    i_reset = 1'b0;
    @(negedge clk);
    read_status("reset_status", 1'b0);
    read_data("reset_rxdata", 1);

    // 1: single good frame
    repeat (5) @(negedge clk);
    send_frame(8'hA5, 1'b1, 1'b0);
    read_status("t1_status", 1'b0);
    read_data("t1_rxdata", 2);
    read_status("t1_status_cleared", 1'b0);

    // 2: short glitch is rejected
    n0 = n_int;
    rx = 1'b0; repeat (3) @(negedge clk); rx = 1'b1;
    repeat (30) @(negedge clk);
    chk_eq("t2_no_int", n_int - n0, 0);
    read_status("t2_status", 1'b0);

    // 3: overrun keeps the first byte
    send_frame(8'h3C, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    send_frame(8'h7E, 1'b1, 1'b0);
    read_status("t3_status", 1'b0);
    write_cycle();
    read_status("t3_status_after_write", 1'b0);
    read_data("t3_rxdata", 1);
    read_status("t3_status_cleared", 1'b0);

    // 4: framing error then held break
    n0 = n_int;
    send_frame(8'h55, 1'b0, 1'b0);
    repeat (40 * 16 - 16) @(negedge clk);
    chk_eq("t4_one_int", n_int - n0, 1);
    read_status("t4_status_break", 1'b1);
    rx = 1'b1;
    repeat (5) @(negedge clk);
    read_status("t4_status_idle", 1'b0);
    read_data("t4_rxdata", 1);

    // 5: read strobe on completion cycle
    repeat (3) @(negedge clk);
    send_frame(8'h3C, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    send_frame(8'h81, 1'b1, 1'b1);
    read_status("t5_status", 1'b0);
    read_data("t5_rxdata", 1);

    // 6: reset during data bit 4
    pb = 8'($urandom);
    n0 = n_int;
    rx = 1'b0; repeat (16) @(negedge clk);
    for (int i = 0; i < 4; i++) begin rx = pb[i]; repeat (16) @(negedge clk); end
    rx = pb[4]; repeat (8) @(negedge clk);
    i_reset = 1'b1; rx = 1'b1;
    @(negedge clk);
    i_reset = 1'b0;
    m_data = 8'h00; m_clear();
    @(negedge clk);
    read_status("t6_status_after_reset", 1'b0);
    repeat (200) @(negedge clk);
    chk_eq("t6_no_int", n_int - n0, 0);
    read_data("t6_rxdata_reset", 1);
    send_frame(8'h42, 1'b1, 1'b0);
    read_data("t6_rxdata", 1);

    // random traffic
    for (int f = 0; f < 24; f++) begin
      repeat ($urandom_range(1, 30)) @(negedge clk);
      if ($urandom_range(0, 5) == 0) begin
        n0 = n_int;
        rx = 1'b0; repeat ($urandom_range(1, 5)) @(negedge clk); rx = 1'b1;
        repeat (20) @(negedge clk);
        chk_eq("rnd_glitch_no_int", n_int - n0, 0);
      end
      b  = 8'($urandom);
      ok = ($urandom_range(0, 5) != 0);
      send_frame(b, ok, 1'b0);
      if (!ok) begin
        repeat ($urandom_range(0, 48)) @(negedge clk);
        read_status("rnd_status_break", 1'b1);
        rx = 1'b1;
        repeat (4) @(negedge clk);
      end
      read_status("rnd_status", 1'b0);
      if ($urandom_range(0, 3) == 0) write_cycle();
      if ($urandom_range(0, 1) == 0) read_data("rnd_rxdata", $urandom_range(1, 3));
    end
    read_status("rnd_final_status", 1'b0);
    read_data("rnd_final_rxdata", 1);

    chk_eq("int_width_one_cycle", n_wide, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
